// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers.
// One word is granted at a time; the frame ends on the DONE_PULSES-th tx_done_tick.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DBIT_WIDTH  = 8,
    parameter int DONE_PULSES = 2,
    parameter int GAP_CYCLES  = 0,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int DCNT_W     = $clog2(DONE_PULSES + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DBIT_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic                          tx_start,
    output logic [DBIT_WIDTH-1:0]         tx_data,
    input  logic                          tx_done_tick,
    output logic                          busy,
    output logic [ID_W-1:0]               grant_id,
    output logic                          frame_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                state;
    logic [ID_W-1:0]       last_grant;
    logic [DCNT_W-1:0]     done_cnt;
    logic [7:0]            gap_cnt;

    logic                  found;
    logic [ID_W-1:0]       winner;
    logic [ID_W-1:0]       cand;
    logic [DBIT_WIDTH-1:0] win_data;
    logic [NUM_REQ-1:0]    win_onehot;

    // Scan from the lowest priority (last_grant itself) up to the highest
    // (last_grant+1), so the final hit is the round-robin winner.
    always_comb begin
        found  = 1'b0;
        winner = last_grant;
        cand   = last_grant;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_data = req_data[i*DBIT_WIDTH +: DBIT_WIDTH];
            end
        end
    end

    assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            done_cnt   <= '0;
            gap_cnt    <= '0;
            req_ack    <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            busy       <= 1'b0;
            grant_id   <= '0;
            frame_done <= 1'b0;
        end else begin
            tx_start   <= 1'b0;
            req_ack    <= '0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable && found) begin
                        tx_data    <= win_data;
                        grant_id   <= winner;
                        last_grant <= winner;
                        req_ack    <= win_onehot;
                        tx_start   <= 1'b1;
                        busy       <= 1'b1;
                        done_cnt   <= '0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tx_done_tick) begin
                        if (done_cnt == DCNT_W'(DONE_PULSES - 1)) begin
                            frame_done <= 1'b1;
                            done_cnt   <= '0;
                            if (GAP_CYCLES > 0) begin
                                gap_cnt <= '0;
                                state   <= S_GAP;
                            end else begin
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
                        end else begin
                            done_cnt <= done_cnt + DCNT_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
                        gap_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized frames
// checked against a round-robin reference model; a second instance covers the gap.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, enable, tx_done_tick;
    logic [NR-1:0]    req_valid, req_ack;
    logic [NR*DW-1:0] req_data;
    logic             tx_start, busy, frame_done;
    logic [DW-1:0]    tx_data;
    logic [1:0]       grant_id;

    logic             g_rst, g_enable, g_tx_done_tick;
    logic [NR-1:0]    g_req_valid, g_req_ack;
    logic [NR*DW-1:0] g_req_data;
    logic             g_tx_start, g_busy, g_frame_done;
    logic [DW-1:0]    g_tx_data;
    logic [1:0]       g_grant_id;

    int n_checks = 0;
    int n_fail   = 0;
    int model_last;
    int g_last;

    uart_tx_arbiter #(.NUM_REQ(NR), .DBIT_WIDTH(DW), .DONE_PULSES(2), .GAP_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .tx_start(tx_start), .tx_data(tx_data), .tx_done_tick(tx_done_tick),
        .busy(busy), .grant_id(grant_id), .frame_done(frame_done)
    );

    uart_tx_arbiter #(.NUM_REQ(NR), .DBIT_WIDTH(DW), .DONE_PULSES(2), .GAP_CYCLES(3)) gdut (
        .clk(clk), .rst(g_rst), .enable(g_enable), .req_valid(g_req_valid), .req_data(g_req_data),
        .req_ack(g_req_ack), .tx_start(g_tx_start), .tx_data(g_tx_data), .tx_done_tick(g_tx_done_tick),
        .busy(g_busy), .grant_id(g_grant_id), .frame_done(g_frame_done)
    );

    // Reference round robin: first pending index strictly after the last grant, wrapping.
    function automatic int model_pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++) begin
            int idx;
            idx = (last + k) % NR;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int i);
        return NR'(1) << i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b1; req_valid = '0; req_data = '0; tx_done_tick = 1'b0;
        g_rst = 1'b1; g_enable = 1'b1; g_req_valid = '0; g_req_data = '0; g_tx_done_tick = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        g_rst = 1'b0;
        model_last = NR - 1;
        g_last = NR - 1;
    endtask

    task automatic pulse_done();
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({tx_start, req_ack, grant_id, tx_data, busy, frame_done} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {tx_start, req_ack, grant_id, tx_data, busy, frame_done});
        end
        n_checks++;
        if ({g_tx_start, g_req_ack, g_grant_id, g_tx_data, g_busy, g_frame_done} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs_gap: got %h expected 0",
                     {g_tx_start, g_req_ack, g_grant_id, g_tx_data, g_busy, g_frame_done});
        end
    endtask

    task automatic test_single();
        req_data = {$urandom, $urandom};
        req_data[2*DW +: DW] = 8'hA5;
        req_valid = 4'b0100;
        tick();
        n_checks++;
        if ({tx_start, req_ack, grant_id, tx_data, busy} !== {1'b1, 4'b0100, 2'd2, 8'hA5, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL single_grant: got %h expected %h",
                     {tx_start, req_ack, grant_id, tx_data, busy}, {1'b1, 4'b0100, 2'd2, 8'hA5, 1'b1});
        end
        model_last = 2;
        req_valid = '0;
        req_data = {$urandom, $urandom};
        tick();
        n_checks++;
        if ({tx_start, req_ack, tx_data, busy} !== {1'b0, 4'b0000, 8'hA5, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL single_pulse_width: got %h expected %h",
                     {tx_start, req_ack, tx_data, busy}, {1'b0, 4'b0000, 8'hA5, 1'b1});
        end
        pulse_done();
        tick();
        tick();
        n_checks++;
        if ({frame_done, busy} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL single_first_done: frame_done,busy=%b expected 01", {frame_done, busy});
        end
        pulse_done();
        n_checks++;
        if ({frame_done, busy, tx_data} !== {1'b1, 1'b0, 8'hA5}) begin
            n_fail++;
            $display("[TB] FAIL single_frame_done: got %h expected %h",
                     {frame_done, busy, tx_data}, {1'b1, 1'b0, 8'hA5});
        end
        tick();
        n_checks++;
        if ({frame_done, busy, tx_start} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL single_after: frame_done,busy,tx_start=%b expected 000",
                     {frame_done, busy, tx_start});
        end
    endtask

    task automatic test_round_robin();
        int hist[$];
        int exp;
        do_reset();
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'hF;
        for (int g = 0; g < 5; g++) begin
            exp = model_pick(req_valid, model_last);
            tick();
            n_checks++;
            if ({tx_start, req_ack, grant_id, tx_data, busy} !==
                {1'b1, onehot(exp), 2'(exp), DW'(16 + exp), 1'b1}) begin
                n_fail++;
                $display("[TB] FAIL rr_grant%0d: got %h expected %h", g,
                         {tx_start, req_ack, grant_id, tx_data, busy},
                         {1'b1, onehot(exp), 2'(exp), DW'(16 + exp), 1'b1});
            end
            if (hist.size() >= 3) begin
                n_checks++;
                for (int h = hist.size() - 3; h < hist.size(); h++) begin
                    if (hist[h] == int'(grant_id)) begin
                        n_fail++;
                        $display("[TB] FAIL rr_fairness: requester %0d acked twice in 4 grants", grant_id);
                        break;
                    end
                end
            end
            hist.push_back(int'(grant_id));
            model_last = exp;
            tick();
            pulse_done();
            tick();
            pulse_done();
            n_checks++;
            if ({frame_done, tx_start} !== 2'b10) begin
                n_fail++;
                $display("[TB] FAIL rr_complete%0d: frame_done,tx_start=%b expected 10", g, {frame_done, tx_start});
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_spurious_done();
        logic bad;
        logic [DW-1:0] w;
        int exp;
        bad = 1'b0;
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            pulse_done();
            if (busy || frame_done || tx_start) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL spurious_idle: activity=%b expected 0", bad);
        end
        w = 8'($urandom);
        req_data[1*DW +: DW] = w;
        req_valid = 4'b0010;
        exp = model_pick(req_valid, model_last);
        tick();
        n_checks++;
        if ({tx_start, req_ack, grant_id, tx_data, busy} !== {1'b1, onehot(exp), 2'(exp), w, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL spurious_grant: got %h expected %h",
                     {tx_start, req_ack, grant_id, tx_data, busy}, {1'b1, onehot(exp), 2'(exp), w, 1'b1});
        end
        model_last = exp;
        req_valid = '0;
        tick();
        pulse_done();
        bad = frame_done;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (frame_done) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL early_done: frame_done=%b expected 0 after one pulse", bad);
        end
        pulse_done();
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL second_done: frame_done=%b expected 1", frame_done);
        end
        tick();
    endtask

    task automatic test_enable();
        logic bad;
        logic [DW-1:0] w1, w2;
        bad = 1'b0;
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        enable = 1'b0;
        req_data[0 +: DW] = w1;
        req_valid = 4'b0001;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx_start || busy) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL enable_gate: activity=%b expected 0", bad);
        end
        enable = 1'b1;
        tick();
        n_checks++;
        if ({tx_start, req_ack, grant_id, tx_data, busy} !== {1'b1, 4'b0001, 2'd0, w1, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL enable_grant: got %h expected %h",
                     {tx_start, req_ack, grant_id, tx_data, busy}, {1'b1, 4'b0001, 2'd0, w1, 1'b1});
        end
        model_last = 0;
        req_data[0 +: DW] = w2;
        enable = 1'b0;
        tick();
        pulse_done();
        tick();
        pulse_done();
        n_checks++;
        if ({frame_done, busy, tx_data} !== {1'b1, 1'b0, w1}) begin
            n_fail++;
            $display("[TB] FAIL enable_drop_wait: got %h expected %h", {frame_done, busy, tx_data}, {1'b1, 1'b0, w1});
        end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_start || busy) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL enable_hold: activity=%b expected 0", bad);
        end
        enable = 1'b1;
        tick();
        n_checks++;
        if ({tx_start, req_ack, grant_id, tx_data} !== {1'b1, 4'b0001, 2'd0, w2}) begin
            n_fail++;
            $display("[TB] FAIL same_requester_regrant: got %h expected %h",
                     {tx_start, req_ack, grant_id, tx_data}, {1'b1, 4'b0001, 2'd0, w2});
        end
        model_last = 0;
        req_valid = '0;
        tick();
        pulse_done();
        pulse_done();
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL enable_final_done: frame_done=%b expected 1", frame_done);
        end
        tick();
    endtask

    task automatic test_gap();
        int edges;
        int exp;
        logic busy_bad;
        g_req_data = {$urandom, $urandom};
        g_req_valid = 4'b0011;
        exp = model_pick(g_req_valid, g_last);
        tick();
        n_checks++;
        if ({g_tx_start, g_grant_id, g_tx_data} !== {1'b1, 2'(exp), g_req_data[exp*DW +: DW]}) begin
            n_fail++;
            $display("[TB] FAIL gap_first_grant: got %h expected %h",
                     {g_tx_start, g_grant_id, g_tx_data}, {1'b1, 2'(exp), g_req_data[exp*DW +: DW]});
        end
        g_last = exp;
        g_tx_done_tick = 1'b1; tick(); g_tx_done_tick = 1'b0;
        tick();
        g_tx_done_tick = 1'b1; tick(); g_tx_done_tick = 1'b0;
        n_checks++;
        if ({g_frame_done, g_busy} !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL gap_frame_done: frame_done,busy=%b expected 11", {g_frame_done, g_busy});
        end
        edges = 0;
        busy_bad = 1'b0;
        exp = model_pick(g_req_valid, g_last);
        while (edges < 10) begin
            tick();
            edges++;
            if (g_tx_start) break;
            if (edges <= 2 && !g_busy) busy_bad = 1'b1;
        end
        n_checks++;
        if (edges != 4 || g_tx_start !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL gap_latency: next grant after %0d edges expected 4", edges);
        end
        n_checks++;
        if (busy_bad !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL gap_busy: busy dropped during gap (%b) expected 0", busy_bad);
        end
        n_checks++;
        if (g_grant_id !== 2'(exp)) begin
            n_fail++;
            $display("[TB] FAIL gap_second_id: got %0d expected %0d", g_grant_id, exp);
        end
        g_last = exp;
        g_req_valid = '0;
        g_tx_done_tick = 1'b1; tick(); tick(); g_tx_done_tick = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_frame();
        int exp;
        req_data = {$urandom, $urandom};
        req_valid = 4'hF;
        exp = model_pick(req_valid, model_last);
        tick();
        n_checks++;
        if ({tx_start, grant_id} !== {1'b1, 2'(exp)}) begin
            n_fail++;
            $display("[TB] FAIL midrst_grant: got %h expected %h", {tx_start, grant_id}, {1'b1, 2'(exp)});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_last = NR - 1;
        n_checks++;
        if ({tx_start, req_ack, grant_id, tx_data, busy, frame_done} !== '0) begin
            n_fail++;
            $display("[TB] FAIL midrst_outputs: got %h expected 0",
                     {tx_start, req_ack, grant_id, tx_data, busy, frame_done});
        end
        exp = model_pick(req_valid, model_last);
        tick();
        n_checks++;
        if ({tx_start, req_ack, grant_id, tx_data} !== {1'b1, onehot(exp), 2'(exp), req_data[exp*DW +: DW]}) begin
            n_fail++;
            $display("[TB] FAIL midrst_regrant: got %h expected %h",
                     {tx_start, req_ack, grant_id, tx_data}, {1'b1, onehot(exp), 2'(exp), req_data[exp*DW +: DW]});
        end
        model_last = exp;
        req_valid = '0;
        pulse_done();
        pulse_done();
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midrst_done: frame_done=%b expected 1", frame_done);
        end
        tick();
    endtask

    task automatic test_random();
        logic [NR-1:0] pend;
        logic [DW-1:0] words[NR];
        logic [DW-1:0] gw;
        logic bad;
        int exp;
        pend = '0;
        for (int i = 0; i < NR; i++) words[i] = '0;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    words[i] = 8'($urandom);
                end
                req_data[i*DW +: DW] = words[i];
            end
            req_valid = pend;
            exp = model_pick(pend, model_last);
            tick();
            if (exp < 0) begin
                n_checks++;
                if (tx_start !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL rand_idle%0d: tx_start=%b expected 0", it, tx_start);
                end
                continue;
            end
            gw = words[exp];
            n_checks++;
            if ({tx_start, req_ack, grant_id, tx_data, busy} !== {1'b1, onehot(exp), 2'(exp), gw, 1'b1}) begin
                n_fail++;
                $display("[TB] FAIL rand_grant%0d: got %h expected %h", it,
                         {tx_start, req_ack, grant_id, tx_data, busy}, {1'b1, onehot(exp), 2'(exp), gw, 1'b1});
            end
            model_last = exp;
            pend[exp] = 1'b0;
            req_valid = pend;
            bad = 1'b0;
            for (int p = 0; p < 2; p++) begin
                repeat ($urandom_range(0, 3)) begin
                    tick();
                    if (tx_start || frame_done || tx_data !== gw) bad = 1'b1;
                end
                pulse_done();
                if (p == 0 && (frame_done || tx_start)) bad = 1'b1;
            end
            n_checks++;
            if (bad !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL rand_wait%0d: spurious activity=%b expected 0", it, bad);
            end
            n_checks++;
            if ({frame_done, busy, tx_start} !== 3'b100) begin
                n_fail++;
                $display("[TB] FAIL rand_done%0d: frame_done,busy,tx_start=%b expected 100", it,
                         {frame_done, busy, tx_start});
            end
        end
        req_valid = '0;
        tick();
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_spurious_done();
        test_enable();
        test_gap();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
